muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Multi-cycle unsigned multiply/divide unit with FSM control. It offloads mult/div from the
//   single-cycle ALU. Executes one shift-add multiply or restoring divide, one bit per clock.
//   Produces a HI/LO result pair and drives a stall line that freezes the pipeline while busy.
//   Sits beside the ALU in EX; the control unit issues start/op, and HI/LO feed mfhi/mflo.
// PARAMETERS
//   WIDTH   32   operand width; product is 2*WIDTH; iteration counter is $clog2(WIDTH)+1 bits
// PORTS
//   clk          in   1      rising-edge clock
//   reset_n      in   1      asynchronous, active-low reset
//   start        in   1      request; sampled only in IDLE or DONE
//   op           in   1      0 = multiply, 1 = divide (both unsigned)
//   a            in   WIDTH  multiplicand / dividend
//   b            in   WIDTH  multiplier / divisor
//   busy         out  1      high in RUN state
//   stall        out  1      = busy (combinational from state)
//   done         out  1      one-cycle pulse: hi/lo/div_by_zero valid
//   hi           out  WIDTH  mult: product[2W-1:W]; div: remainder
//   lo           out  WIDTH  mult: product[W-1:0];  div: quotient
//   div_by_zero  out  1      set with done when op=1 and b==0; holds until next accepted start
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE; busy=stall=done=div_by_zero=0; hi=lo=0; work regs 0.
//   States: IDLE, RUN, DONE.
//   IDLE/DONE + start=1 at edge E0: latch a, b, op into work regs; clear div_by_zero.
//     op=1, b==0 -> DONE. lo={WIDTH{1'b1}}, hi=a, div_by_zero=1. done is high in the cycle after E0.
//     otherwise  -> RUN, count=WIDTH.
//   RUN: one iteration per edge; count decrements; the edge where count goes 1->0 moves to DONE.
//     Exactly WIDTH iterations. done is high in the cycle after edge E0+WIDTH.
//   DONE: lasts one cycle, done=1. Goes to IDLE if start=0; start=1 is accepted (back-to-back).
//   IDLE + start=0: stay in IDLE.
//   Multiply: 2W accumulator, shift-add on multiplier LSB. Full unsigned product, no truncation.
//   Divide: restoring, W+1-bit partial remainder. Quotient is floor(a/b), remainder is a mod b.
//   hi/lo change only on the edge entering DONE. They hold through IDLE and the next RUN.
//   Work registers are internal; hi/lo never show partial results.
//   start while in RUN: ignored, with no effect on state or results.
//     Changes on a/b/op during RUN: ignored, because operands are latched at E0.
//   Reset asserted mid-RUN: abort immediately to the reset values. No done pulse for the aborted op.
//   op or operands X/Z while start=0: no effect.
// TESTING
//   1 reset_n=0 with random inputs toggling -> busy=stall=done=0, hi=lo=0; stays so until release.
//   2 mult a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 32 edges after start;
//     hi=0xFFFFFFFE, lo=0x00000001, busy high 32 cycles.
//   3 div a=100 b=7 -> after 32 edges: lo=14, hi=2, div_by_zero=0.
//     Then a=7 b=100 -> lo=0, hi=7.
//   4 div a=5 b=0 -> done 1 cycle after start; lo=0xFFFFFFFF, hi=5, div_by_zero=1.
//     Next accepted mult clears div_by_zero.
//   5 mult 3*4; pulse start with a=9 b=9 and change a/b mid-RUN -> result still hi=0, lo=12.
//     start held in DONE -> new op accepted, busy next cycle.
//   6 div 1000/3; assert reset_n=0 at RUN cycle 10 -> immediate reset values, no done.
//     Release and run mult 6*7 -> lo=42, hi=0.
//   All: scoreboard against a*b, a/b, a%b for 1000 random pairs (including b=1, a<b, a=0).
//     Assert done never occurs without a prior accepted start.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//   Multi-cycle unsigned multiply / divide unit that sits beside the ALU in EX.
//   It runs one shift-add multiply or one restoring divide, one bit per clock,
//   and holds the pipeline through stall while it works. hi/lo feed mfhi/mflo.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request strobe (see handshake below)
//   op           0 = multiply, 1 = divide (both unsigned)
//   a            multiplicand / dividend
//   b            multiplier / divisor
//   busy         high while an operation iterates (RUN)
//   stall        same as busy, for the pipeline freeze
//   done         one-cycle pulse: hi/lo/div_by_zero are valid
//   hi           mult: product[2W-1:W]   div: remainder
//   lo           mult: product[W-1:0]    div: quotient
//   div_by_zero  set with done for a divide by 0; held until next accepted start
//   state_dbg    current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is a request that is accepted on any rising edge where the
//   unit is in IDLE or DONE; a, b and op are captured on that same edge. While
//   busy is high, start and the operand inputs are ignored. done marks the one
//   cycle in which a new result has just been written to hi/lo; holding start
//   through that cycle issues the next operation back-to-back.
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Work registers: operands captured at start, iteration counter, and the
    // per-operation accumulators. None of these are visible on hi/lo.
    logic             op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    count;
    logic [2*WIDTH-1:0] prod;   // upper half accumulates, lower half holds the multiplier
    logic [WIDTH-1:0] rem;      // partial remainder (always < divisor between steps)
    logic [WIDTH-1:0] quo;      // dividend shifts out the top, quotient bits shift in

    logic accept;
    logic div0;
    logic last_iter;

    // start is only meaningful when not iterating; gating here also keeps
    // undriven op/a/b from having any effect while start is low.
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign div0      = op && (b == '0);
    assign last_iter = (state == S_RUN) && (count == CW'(1));

    // ------------------------------------------------------------------
    // One iteration of each algorithm, computed combinationally.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH:0]     rem_shift;   // the W+1-bit partial remainder before trial subtract
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_diff;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;

    always_comb begin
        // Shift-add: add the multiplicand into the upper half when the current
        // multiplier LSB is 1, then shift the whole accumulator right. The carry
        // out of the add lands in the top bit, so nothing is truncated.
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_r} : '0);
        prod_step = {mul_sum, prod[WIDTH-1:1]};

        // Restoring divide: bring down the next dividend bit, subtract the
        // divisor if it fits. When it fits the true difference is < 2^W, so
        // the W-bit modular subtraction is exact.
        rem_shift = {rem, quo[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, b_r});
        rem_diff  = rem_shift[WIDTH-1:0] - b_r;
        if (rem_ge) begin
            rem_step = rem_diff;
            quo_step = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = rem_shift[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    // Divide by zero has no iterations; the result is known now.
                    state_nxt = div0 ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (count == CW'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state == S_RUN);
        stall     = (state == S_RUN);
        done      = (state == S_DONE);
        state_dbg = state;
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r        <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            count       <= '0;
            prod        <= '0;
            rem         <= '0;
            quo         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                op_r        <= op;
                a_r         <= a;
                b_r         <= b;
                count       <= CW'(WIDTH);
                prod        <= {{WIDTH{1'b0}}, b};
                rem         <= '0;
                quo         <= a;
                div_by_zero <= div0;
                if (div0) begin
                    hi <= a;
                    lo <= '1;
                end
            end else if (state == S_RUN) begin
                count <= count - CW'(1);
                if (op_r) begin
                    rem <= rem_step;
                    quo <= quo_step;
                end else begin
                    prod <= prod_step;
                end
                // Results are published only on the edge that enters DONE,
                // straight from the final iteration's value.
                if (last_iter) begin
                    hi <= op_r ? rem_step : prod_step[2*WIDTH-1:WIDTH];
                    lo <= op_r ? quo_step : prod_step[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Bench for muldiv_sequencer. A transaction-level model predicts, for every
//   cycle, busy/done and the visible hi/lo/div_by_zero from plain arithmetic
//   (a*b, a/b, a%b) plus the latency rule "result appears WIDTH cycles after an
//   accepted start, or 1 cycle for divide by zero". A compare process checks
//   the DUT against it on every falling edge; directed tests add literal pins.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         start   = 1'b0;
    logic         op      = 1'b0;
    logic [W-1:0] a       = '0;
    logic [W-1:0] b       = '0;

    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;
    logic [1:0]   state_dbg;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected result word: {div_by_zero, hi, lo}
    logic [2*W:0] exp_q[$];
    int           m_cnt   = 0;
    logic         m_done  = 1'b0;
    logic         m_dbz   = 1'b0;
    logic [W-1:0] m_hi    = '0;
    logic [W-1:0] m_lo    = '0;
    int           accepts    = 0;
    int           dones_seen = 0;

    function automatic logic [2*W:0] golden(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        if (!o) begin
            p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            return {1'b0, p};
        end else if (y == '0) begin
            return {1'b1, x, {W{1'b1}}};
        end else begin
            return {1'b0, x % y, x / y};
        end
    endfunction

    initial begin
        logic [2*W:0] r;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                exp_q.delete();
                m_cnt  = 0;
                m_done = 1'b0;
                m_dbz  = 1'b0;
                m_hi   = '0;
                m_lo   = '0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                m_done = (m_cnt == 0);
                if (m_done) begin
                    r = exp_q.pop_front();
                    {m_dbz, m_hi, m_lo} = r;
                end
            end else begin
                m_done = 1'b0;
                if (start) begin
                    accepts++;
                    exp_q.push_back(golden(op, a, b));
                    m_dbz = 1'b0;
                    if (op && (b == '0)) begin
                        r = exp_q.pop_front();
                        {m_dbz, m_hi, m_lo} = r;
                        m_done = 1'b1;
                    end else begin
                        m_cnt = W;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("busy",        busy,        m_cnt > 0);
            chk("stall",       stall,       m_cnt > 0);
            chk("done",        done,        m_done);
            chk("div_by_zero", div_by_zero, m_dbz);
            chk("hi",          hi,          m_hi);
            chk("lo",          lo,          m_lo);
            if (done === 1'b1) begin
                dones_seen++;
                chk("done_after_start", dones_seen <= accepts, 1);
            end
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cyc);
        busy_cyc = 0;
        for (int i = 0; i < 64 && done !== 1'b1; i++) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
        end
        chk("done_reached", done, 1);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int cyc;
        int mode;
        logic          ro;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;

        // 1: reset held with inputs toggling
        reset_n = 1'b0;
        repeat (6) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            op    = 1'($urandom_range(0, 1));
            a     = $urandom;
            b     = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi",   hi,   0);
        chk("rst_lo",   lo,   0);
        reset_n = 1'b1;
        @(negedge clk);

        // 2: full-range multiply
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc);
        chk("t2_busy_cycles", cyc, 32);
        chk("t2_hi", hi, 64'h0000_0000_FFFF_FFFE);
        chk("t2_lo", lo, 64'h0000_0000_0000_0001);
        @(negedge clk);

        // 3: divides
        issue(1'b1, 32'd100, 32'd7);
        wait_done(cyc);
        chk("t3_busy_cycles", cyc, 32);
        chk("t3_lo", lo, 14);
        chk("t3_hi", hi, 2);
        chk("t3_dbz", div_by_zero, 0);
        @(negedge clk);
        issue(1'b1, 32'd7, 32'd100);
        wait_done(cyc);
        chk("t3b_lo", lo, 0);
        chk("t3b_hi", hi, 7);
        @(negedge clk);

        // 4: divide by zero, then a multiply clears the flag
        issue(1'b1, 32'd5, 32'd0);
        wait_done(cyc);
        chk("t4_latency", cyc, 0);
        chk("t4_lo", lo, 64'h0000_0000_FFFF_FFFF);
        chk("t4_hi", hi, 5);
        chk("t4_dbz", div_by_zero, 1);
        @(negedge clk);
        chk("t4_dbz_hold", div_by_zero, 1);
        issue(1'b0, 32'd2, 32'd3);
        chk("t4_dbz_cleared", div_by_zero, 0);
        chk("t4_hi_held", hi, 5);
        wait_done(cyc);
        chk("t4_mult_lo", lo, 6);
        @(negedge clk);

        // 5: start and operand changes during RUN are ignored; back-to-back
        issue(1'b0, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        issue(1'b0, 32'd9, 32'd9);
        repeat (5) begin
            a  = $urandom;
            b  = $urandom;
            op = 1'b1;
            @(negedge clk);
        end
        wait_done(cyc);
        chk("t5_hi", hi, 0);
        chk("t5_lo", lo, 12);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd5;
        b     = 32'd5;
        @(negedge clk);
        chk("t5_b2b_busy", busy, 1);
        start = 1'b0;
        wait_done(cyc);
        chk("t5_b2b_lo", lo, 25);
        @(negedge clk);

        // 6: reset mid-RUN aborts; then a clean multiply
        issue(1'b1, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_abort_busy", busy, 0);
        chk("t6_abort_done", done, 0);
        chk("t6_abort_hi",   hi,   0);
        chk("t6_abort_lo",   lo,   0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(1'b0, 32'd6, 32'd7);
        wait_done(cyc);
        chk("t6_lo", lo, 42);
        chk("t6_hi", hi, 0);
        @(negedge clk);

        // random pairs, with edge classes mixed in; odd iterations go back-to-back
        for (int i = 0; i < 1000; i++) begin
            mode = i % 8;
            ro   = 1'($urandom_range(0, 1));
            ra   = $urandom;
            rb   = $urandom;
            case (mode)
                0: rb = 32'd1;
                1: begin
                    rb = $urandom_range(2, 32'hFFFF_FFFF);
                    ra = $urandom_range(0, rb - 1);
                end
                2: ra = '0;
                3: begin
                    ra = $urandom_range(0, 255);
                    rb = $urandom_range(0, 255);
                end
                default: ;
            endcase
            issue(ro, ra, rb);
            wait_done(cyc);
            if ((i % 2) == 0) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
